// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Instruction fetch sequencer for a synchronous-read instruction
//               memory. Owns the fetch PC, issues at most one read per cycle,
//               tags each returned word with its PC and hands it to decode
//               through a 2-entry valid/ready buffer. Redirects flush both the
//               buffer and any in-flight read.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [DATA_W-1:0] imem_instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  // PC increment truncated to the address width so the PC wraps naturally.
  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;

  logic [ADDR_W-1:0]   r_pc;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_tag;

  // Buffer: entry 0 is always the oldest word (the head), entry 1 the next.
  logic [1:0]          r_count;
  logic [DATA_W-1:0]   r_instr0;
  logic [ADDR_W-1:0]   r_pc0;
  logic [DATA_W-1:0]   r_instr1;
  logic [ADDR_W-1:0]   r_pc1;

  logic                w_pop;
  logic                w_push;
  logic [2:0]          w_occ;
  logic                w_issue;

  // Handshake and issue decisions. Occupancy counts buffered words plus the
  // word still in the memory pipeline, less the one leaving this cycle, so a
  // new read is only launched when there is guaranteed room for its result.
  always_comb begin
    w_pop   = (r_count != 2'd0) && out_ready;
    w_push  = r_inflight && !redirect_valid;
    w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue = (r_state == S_FETCH) && !redirect_valid && (w_occ < 3'd2);
  end

  // Control FSM; busy is registered alongside the state it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!enable) begin
            r_state <= S_DRAIN;
          end
          r_busy <= 1'b1;
        end
        S_DRAIN: begin
          if (enable) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end else if (!r_inflight && (r_count == 2'd0)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch PC and in-flight tracking. A redirect overrides any issue; when no
  // read is issued the PC holds and the memory simply re-reads that address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        r_pc  <= r_pc + C_PC_STEP;
      end
    end
  end

  // Two-entry FIFO. The head lives in fixed registers so the outputs never
  // see the memory data combinationally; pops shift entry 1 into entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_instr0 <= '0;
      r_pc0    <= '0;
      r_instr1 <= '0;
      r_pc1    <= '0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_instr0 <= imem_instruction;
            r_pc0    <= r_tag;
          end else begin
            r_instr1 <= imem_instruction;
            r_pc1    <= r_tag;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_instr0 <= r_instr1;
          r_pc0    <= r_pc1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_instr0 <= imem_instruction;
            r_pc0    <= r_tag;
          end else begin
            r_instr0 <= r_instr1;
            r_pc0    <= r_pc1;
            r_instr1 <= imem_instruction;
            r_pc1    <= r_tag;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_pc   = r_pc;
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_instr0;
  assign out_pc    = r_pc0;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Directed self-checking bench for fetch_controller covering
//               reset, streaming, back-pressure, redirect, drain, PC wrap and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_pc;
  logic [DATA_W-1:0] imem_instruction;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;

  int n_compared;
  int n_mismatched;

  fetch_controller #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC ('0),
    .PC_STEP  (4)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model: mem[a] = A000_0000 | a.
  always @(posedge clk) imem_instruction <= 32'hA000_0000 | {22'd0, imem_pc};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input int pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"},    {22'd0, out_pc},    pc);
    chk({tag, "_instr"}, out_instr,          32'hA000_0000 | pc);
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    rst_n          = 1'b0;
    enable         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_pc",    {22'd0, imem_pc},   32'd0);
    chk("rst_outpc", {22'd0, out_pc},    32'd0);
    chk("rst_instr", out_instr,          32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_pc",   {22'd0, imem_pc},   32'd0);

    // Basic stream: enable sampled at E0, first word visible after E2
    enable = 1'b1;
    step();                                        // E0
    chk("e0_valid", {31'd0, out_valid}, 32'd0);
    chk("e0_busy",  {31'd0, busy},      32'd1);
    step();                                        // E1
    chk("e1_valid", {31'd0, out_valid}, 32'd0);
    step();                                        // E2
    chk_head("s0", 0);
    step();
    chk_head("s1", 4);
    step();
    chk_head("s2", 8);
    chk("s2_imem_pc", {22'd0, imem_pc}, 32'd16);

    // Back-pressure with pc 8 at the head
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_head("bp_hold", 8);
    end
    chk("bp_imem_pc", {22'd0, imem_pc}, 32'd16);
    out_ready = 1'b1;
    step();
    chk_head("bp_r0", 12);
    step();
    chk_head("bp_r1", 16);
    step();
    chk_head("bp_r2", 20);

    // Redirect to 100 while streaming at pc 20
    redirect_valid = 1'b1;
    redirect_pc    = 10'd100;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid0", {31'd0, out_valid}, 32'd0);
    chk("rd_pc",     {22'd0, imem_pc},   32'd100);
    step();
    chk("rd_valid1", {31'd0, out_valid}, 32'd0);
    step();
    chk_head("rd_t0", 100);
    step();
    chk_head("rd_t1", 104);
    step();
    chk_head("rd_t2", 108);

    // Drain: words already issued are still delivered, then fetch stops
    enable = 1'b0;
    step();
    chk_head("dr_0", 112);
    step();
    chk_head("dr_1", 116);
    step();
    chk("dr_empty", {31'd0, out_valid}, 32'd0);
    chk("dr_busy1", {31'd0, busy},      32'd1);
    step();
    chk("dr_busy0", {31'd0, busy},      32'd0);
    chk("dr_pc",    {22'd0, imem_pc},   32'd120);
    step();
    step();
    chk("dr_frozen", {22'd0, imem_pc},  32'd120);
    chk("dr_novalid", {31'd0, out_valid}, 32'd0);

    // Resume from the frozen PC
    enable = 1'b1;
    step();
    step();
    chk("rs_wait", {31'd0, out_valid}, 32'd0);
    step();
    chk_head("rs_0", 120);

    // Wrap: redirect to 1016
    redirect_valid = 1'b1;
    redirect_pc    = 10'd1016;
    step();
    redirect_valid = 1'b0;
    chk("wr_valid0", {31'd0, out_valid}, 32'd0);
    step();
    chk("wr_valid1", {31'd0, out_valid}, 32'd0);
    step();
    chk_head("wr_0", 1016);
    step();
    chk_head("wr_1", 1020);
    step();
    chk_head("wr_2", 0);
    step();
    chk_head("wr_3", 4);

    // Fill the buffer to two words, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    step();
    step();
    step();
    chk_head("ar_head", 4);
    chk("ar_busy_pre", {31'd0, busy}, 32'd1);
    chk("ar_pc_pre", {22'd0, imem_pc}, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_busy",  {31'd0, busy},      32'd0);
    chk("ar_pc",    {22'd0, imem_pc},   32'd0);
    step();
    rst_n  = 1'b1;
    enable = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the synchronous-read instruction_memory: owns the fetch PC, issues one read per cycle, and captures returned words with their PC tags.
- Delivers captured words to decode through a 2-entry valid/ready buffer, so back-pressure never loses an in-flight word.
- Accepts branch/jump redirects, which flush the buffer and any in-flight read.
- Sits between the PC/branch logic and the decode stage.

Parameters:
- ADDR_W, 10, width of the PC and the instruction_memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 0, fetch PC loaded on reset.
- PC_STEP, 4, increment applied to the PC per issued fetch.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 = run fetch, 0 = stop issuing and drain.
- redirect_valid  input  1  one-cycle pulse; load redirect_pc and flush.
- redirect_pc  input  ADDR_W  redirect target.
- imem_pc  output  ADDR_W  registered; drives instruction_memory pc.
- imem_instruction  input  DATA_W  memory output; equals mem[imem_pc sampled at the previous edge].
- out_valid  output  1  buffer head valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  DATA_W  instruction at the buffer head.
- out_pc  output  ADDR_W  PC tag of out_instr.
- busy  output  1  1 when state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - imem_pc=RESET_PC; state=IDLE.
  - Buffer count=0; inflight=0.
  - out_valid=0, out_instr=0, out_pc=0, busy=0.
- States: IDLE, FETCH, DRAIN.
  - IDLE->FETCH when enable=1.
  - FETCH->DRAIN when enable=0.
  - DRAIN->FETCH when enable=1.
  - DRAIN->IDLE when enable=0, inflight=0 and count=0.
- pop = out_valid & out_ready.
- issue = (state==FETCH) & !redirect_valid & (count + inflight - pop < 2).
- At an edge where issue=1:
  - Set inflight=1 with tag = current imem_pc.
  - imem_pc <= imem_pc + PC_STEP, mod 2^ADDR_W, so 1020+4 wraps to 0 when ADDR_W=10.
- At an edge where issue=0:
  - imem_pc holds (the memory re-reading the same address is harmless).
  - inflight is cleared.
- Capture: at an edge where inflight=1 and there is no redirect, push {imem_instruction, tag} into the buffer. Push and pop may occur on the same edge.
- Buffer:
  - 2 entries, FIFO order.
  - out_* always reflect the oldest entry; they are registered, with no combinational path from imem_instruction.
  - Overflow is impossible by construction of the issue rule.
- Latency:
  - Issue at edge E gives out_valid=1 after edge E+1.
  - enable rising (sampled at E0) gives the first issue at E1, so out_valid=1 after E2.
  - Steady state with out_ready=1: one instruction per cycle.
- Back-pressure:
  - out_ready=0 with out_valid=1 holds out_* stable.
  - The buffer fills to 2 and issue stops; no word is dropped or duplicated.
- Redirect (any state, highest priority):
  - At the edge: buffer cleared, inflight cleared, imem_pc <= redirect_pc.
  - No issue or capture on that edge.
  - A pop on the same edge counts as accepted.
  - out_valid=0 after the edge.
  - In FETCH, the first target word is valid 2 edges later.
  - In IDLE/DRAIN, only the PC is loaded.
- Drain: in DRAIN an in-flight word is still captured, and buffered words are still delivered.
- Reset mid-operation discards all state immediately; fetch restarts from RESET_PC.

Test Plan:
- Bench memory model: mem[a]=32'hA000_0000|a.
- Basic stream: reset, enable=1, out_ready=1 -> out_valid first high 2 cycles after enable is sampled. Sequence (out_pc, out_instr): (0, A0000000), (4, A0000004), (8, A0000008), ..., one per cycle, no gaps.
- Back-pressure: out_ready=0 for 5 cycles with pc 8 at the head -> out_pc=8 held; imem_pc stops at 16. On release, out_pc sequence 8, 12, 16, with no loss or duplicates.
- Redirect: redirect_valid with redirect_pc=100 while streaming at pc 20 -> out_valid=0 for 2 cycles. Then out_pc 100, 104, 108; no stale 20/24/28 appears.
- Drain/enable: enable=0 mid-stream -> the remaining issued words (at most 2) are delivered, then busy=0 and imem_pc is frozen. enable=1 resumes at the frozen PC.
- Wrap: redirect_pc=1016 -> out_pc sequence 1016, 1020, 0, 4.
- Async reset: rst_n=0 mid-cycle with 2 words buffered -> out_valid=0, busy=0, imem_pc=0 immediately, without waiting for a clock edge.
